// File: rtl/pipe_stall_sched.sv
// pipe_stall_sched: central stall/flush scheduler for the 5-stage pipeline.
// Merges per-stage stall requests into one stop vector (bit0 = PC .. bit5 = WB),
// sequences the multi-cycle EX multiply/divide unit and keeps a saturating
// count of stalled cycles for performance debug.
module pipe_stall_sched #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             md_run,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // Stop vectors: a request from stage k stops stages 0..k; the bubble is
    // created by the stage registers at the Stop/NoStop boundary.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // The start cycle is already a busy cycle, so the RUN phase lasts N-1 cycles.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 32'd1);
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_cnt;
    logic [5:0]         w_cnt_nxt;
    logic               r_flush;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic               w_md_busy;
    logic               w_run_raw;
    logic               w_done_raw;
    logic [5:0]         w_stall;

    // Saturating increment used by the performance counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // FSM state and md down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Decode of the current state into md busy/run/done indications.
    always_comb begin
        w_md_busy  = 1'b0;
        w_run_raw  = 1'b0;
        w_done_raw = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_md_start) begin
                    w_md_busy = 1'b1;
                end else begin
                    w_md_busy = 1'b0;
                end
            end
            S_RUN: begin
                w_md_busy = 1'b1;
                w_run_raw = 1'b1;
            end
            S_DONE: begin
                w_done_raw = 1'b1;
            end
            default: begin
                w_md_busy  = 1'b0;
                w_run_raw  = 1'b0;
                w_done_raw = 1'b0;
            end
        endcase
    end

    // Next-state and counter logic; a flush request overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_req) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_md_start) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 6'd0;
                    end
                end
                S_RUN: begin
                    // Counts remaining RUN cycles; it reaches zero on the DONE edge.
                    // The md unit keeps iterating even while MEM holds the pipe.
                    w_cnt_nxt = r_cnt - 6'd1;
                    if (r_cnt <= 6'd1) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 6'd0;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    // Result is held until the EX instruction can actually advance.
                    if (stallreq_mem) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // Priority merge of stall sources: MEM over EX md over ID; flush clears all.
    always_comb begin
        w_stall = STALL_NONE;
        if (!rst || r_flush) begin
            w_stall = STALL_NONE;
        end else if (stallreq_mem) begin
            w_stall = STALL_MEM;
        end else if (w_md_busy) begin
            w_stall = STALL_EX;
        end else if (stallreq_id) begin
            w_stall = STALL_ID;
        end else begin
            w_stall = STALL_NONE;
        end
    end

    // One-cycle registered copy of the flush request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= flush_req;
        end
    end

    // Saturating count of cycles in which any stage was stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (w_stall != STALL_NONE) begin
            r_stall_cycles <= sat_inc(r_stall_cycles);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall        = w_stall;
    assign flush        = r_flush;
    assign md_run       = rst & w_run_raw & ~flush_req;
    assign md_done      = rst & w_done_raw & ~flush_req;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Self-checking bench for pipe_stall_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an
// operation-level model (age of the md op since its start cycle).
module tb_pipe_stall_sched;

    localparam int DIVN = 33;
    localparam int MULN = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id = 1'b0;
    logic start = 1'b0;
    logic isdiv = 1'b0;
    logic mem = 1'b0;
    logic freq = 1'b0;

    logic [5:0]  stall, stall4;
    logic        flush, flush4, run, run4, done, done4;
    logic [31:0] sc;
    logic [3:0]  sc4;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stall_sched #(.DIV_CYCLES(DIVN), .MUL_CYCLES(MULN), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .stallreq_id(id), .ex_md_start(start),
        .ex_md_is_div(isdiv), .stallreq_mem(mem), .flush_req(freq),
        .stall(stall), .flush(flush), .md_run(run), .md_done(done),
        .stall_cycles(sc)
    );

    pipe_stall_sched #(.DIV_CYCLES(DIVN), .MUL_CYCLES(MULN), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .stallreq_id(id), .ex_md_start(start),
        .ex_md_is_div(isdiv), .stallreq_mem(mem), .flush_req(freq),
        .stall(stall4), .flush(flush4), .md_run(run4), .md_done(done4),
        .stall_cycles(sc4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An md op is "active" from the cycle after its start; m_age is the number of
    // cycles since the start cycle. Busy for ages 0..N-1, result from age N on.
    bit     m_active = 1'b0;
    int     m_age = 0;
    int     m_n = 0;
    bit     m_flush_q = 1'b0;
    longint m_cnt = 0;

    function automatic logic [5:0] exp_stall();
        if (!rst || m_flush_q) return 6'b000000;
        if (mem) return 6'b011111;
        if ((!m_active && start) || (m_active && m_age < m_n)) return 6'b001111;
        if (id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic exp_run();
        return rst && m_active && (m_age < m_n) && !freq;
    endfunction

    function automatic logic exp_done();
        return rst && m_active && (m_age >= m_n) && !freq;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active  <= 1'b0;
            m_age     <= 0;
            m_n       <= 0;
            m_flush_q <= 1'b0;
            m_cnt     <= 0;
        end else begin
            if (exp_stall() != 6'b000000) m_cnt <= m_cnt + 1;
            m_flush_q <= freq;
            if (freq) begin
                m_active <= 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_age    <= 1;
                    m_n      <= isdiv ? DIVN : MULN;
                end
            end else if (m_age >= m_n && !mem) begin
                m_active <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_stall", stall, exp_stall());
            chk("m_stall_w4", stall4, exp_stall());
            chk("m_flush", flush, m_flush_q);
            chk("m_flush_w4", flush4, m_flush_q);
            chk("m_md_run", run, exp_run());
            chk("m_md_run_w4", run4, exp_run());
            chk("m_md_done", done, exp_done());
            chk("m_md_done_w4", done4, exp_done());
            chk("m_cnt32", sc, (m_cnt >= 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_cnt);
            chk("m_cnt4", sc4, (m_cnt >= 15) ? 64'd15 : m_cnt);
        end
    end

    task automatic do_reset();
        id = 1'b0; start = 1'b0; isdiv = 1'b0; mem = 1'b0; freq = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit saw_done;

    initial begin
        // Reset held with every request high.
        rst = 1'b0; id = 1'b1; start = 1'b1; isdiv = 1'b1; mem = 1'b1; freq = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_stall", stall, 6'b000000);
        chk("rst_flush", flush, 1'b0);
        chk("rst_cnt", sc, 32'd0);
        chk("rst_run", run, 1'b0);
        chk("rst_done", done, 1'b0);

        // Release with only ID requesting.
        start = 1'b0; isdiv = 1'b0; mem = 1'b0; freq = 1'b0; id = 1'b1;
        cyc();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rel_stall", stall, 6'b000111);
        cyc();
        chk("rel_cnt", sc, 32'd1);

        // Unobstructed divide.
        do_reset();
        start = 1'b1; isdiv = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk); #1;
            chk("div_stall", stall, (c <= 33) ? 6'b001111 : 6'b000000);
            chk("div_run", run, (c >= 2 && c <= 33));
            chk("div_done", done, (c == 34));
            cyc();
            if (c == 34) start = 1'b0;
        end
        chk("div_cnt", sc, 32'd33);
        @(negedge clk); #1;
        chk("div_idle_done", done, 1'b0);
        chk("div_idle_stall", stall, 6'b000000);

        // Multiply behind a 5-cycle MEM wait.
        do_reset();
        start = 1'b1; isdiv = 1'b0; mem = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            chk("mul_stall", stall, (c <= 5) ? 6'b011111 : 6'b000000);
            chk("mul_run", run, (c == 2));
            chk("mul_done", done, (c >= 3 && c <= 6));
            cyc();
            if (c == 5) mem = 1'b0;
            if (c == 6) start = 1'b0;
        end
        chk("mul_cnt", sc, 32'd5);

        // Priority: MEM over ID, then ID alone, then EX md over ID.
        do_reset();
        id = 1'b1; mem = 1'b1;
        @(negedge clk); #1;
        chk("pri_mem_id", stall, 6'b011111);
        cyc();
        mem = 1'b0;
        @(negedge clk); #1;
        chk("pri_id", stall, 6'b000111);
        cyc();
        start = 1'b1; isdiv = 1'b0;
        @(negedge clk); #1;
        chk("pri_ex_id", stall, 6'b001111);

        // Flush on RUN cycle 10 of a divide.
        do_reset();
        start = 1'b1; isdiv = 1'b1;
        repeat (10) cyc();
        freq = 1'b1;
        @(negedge clk); #1;
        chk("fl_run_suppr", run, 1'b0);
        cyc();
        freq = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        chk("fl_flush", flush, 1'b1);
        chk("fl_stall", stall, 6'b000000);
        chk("fl_run", run, 1'b0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            @(negedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("fl_no_done", saw_done, 1'b0);
        id = 1'b1;
        @(negedge clk); #1;
        chk("fl_idle", stall, 6'b000111);

        // Saturation of the 4-bit counter.
        do_reset();
        id = 1'b1;
        repeat (20) cyc();
        chk("sat_w4", sc4, 4'hF);
        chk("sat_w32", sc, 32'd20);

        // Randomized traffic; ex_md_start is held while the model says the op is in EX.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) != 0);
            id   = ($urandom_range(0, 3) == 0);
            mem  = ($urandom_range(0, 3) == 0);
            freq = ($urandom_range(0, 29) == 0);
            if (m_active) begin
                start = 1'b1;
            end else begin
                start = ($urandom_range(0, 2) == 0);
                isdiv = ($urandom_range(0, 3) == 0);
            end
            cyc();
        end

        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stall_sched.md
Name: pipe_stall_sched

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the shared `StallBus` vector consumed by every stage register.
- Sequences the multi-cycle EX multiply/divide unit.
- Counts stall cycles for performance debug.

Parameters:
- DIV_CYCLES, 33, cycles a divide occupies the md unit (≥2)
- MUL_CYCLES, 2, cycles a multiply occupies the md unit (≥2)
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- stallreq_id  in  1  load-use hazard from ID, combinational
- ex_md_start  in  1  EX holds a mul/div instruction; held high until the instruction leaves EX
- ex_md_is_div  in  1  1 = divide, 0 = multiply; valid with ex_md_start
- stallreq_mem  in  1  MEM waiting on data SRAM
- flush_req  in  1  exception/eret flush, 1-cycle pulse
- stall  out  `StallBus` (6)  per-stage stop vector; bit0 = PC … bit5 = WB; `Stop` = 1
- flush  out  1  registered flush to all stage registers
- md_run  out  1  md unit enable: iterate this cycle
- md_done  out  1  md result valid for the EX instruction
- stall_cycles  out  CNT_W  saturating count of cycles with stall != 0

Behaviour:
- Stall encoding: a request from stage k sets stall[0..k] = 1 and stall[5..k+1] = 0.
  - MEM request → 6'b011111
  - EX request → 6'b001111
  - ID request → 6'b000111
  - A bubble enters at the boundary where stall[k] = Stop and stall[k+1] = NoStop; stage registers handle this.
- Stall priority: stallreq_mem > EX md stall > stallreq_id. stall is combinational from the inputs and the FSM state. No request gives 6'b000000.
- FSM states: IDLE, RUN, DONE. Down-counter cnt is 6 bits.
- IDLE:
  - If ex_md_start is high: load cnt = (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1, then go to RUN.
  - The EX md stall is asserted in this same cycle, because the start cycle counts as a busy cycle.
- RUN:
  - md_run = 1 and the EX md stall is asserted.
  - cnt decrements each cycle.
  - When cnt == 0, go to DONE on the next edge.
  - The counter runs regardless of stallreq_mem, since the md unit is independent of the pipeline hold.
- DONE:
  - md_done = 1 and no EX md stall.
  - Stay in DONE while stallreq_mem = 1, because the EX instruction cannot advance yet.
  - Return to IDLE on the first cycle with stallreq_mem = 0; the instruction leaves EX on that edge.
  - ex_md_start is ignored while in DONE.
- Total EX hold for an unobstructed op is N cycles (N = DIV_CYCLES or MUL_CYCLES). md_done is seen in cycle N+1, which is also the advance cycle.
- flush:
  - flush = flush_req registered, a 1-cycle pulse one cycle after the request.
  - In the flush_req cycle the FSM is forced to IDLE next edge, cnt is cleared, and md_run/md_done are suppressed.
  - While flush = 1, stall is forced to 0.
- stall_cycles: increments on each edge where stall != 0 and saturates at all-ones; it does not wrap.
- Async reset (rst = 0) sets: FSM = IDLE, cnt = 0, flush = 0, stall_cycles = 0.
  - stall, md_run and md_done read 0 while reset is held, because inputs are gated by rst.
  - Reset mid-RUN abandons the operation with no md_done.
- Simultaneous events:
  - stallreq_id together with the EX md stall → 6'b001111.
  - flush_req together with ex_md_start in IDLE → flush wins; no RUN entry.

Test Plan:
- Reset:
  - Stimulus: rst low with all requests high.
  - Required: stall = 0, flush = 0, stall_cycles = 0.
  - Release rst with only stallreq_id high → stall = 6'b000111 and stall_cycles = 1 after one edge.
- Divide, DIV_CYCLES = 33:
  - Stimulus: ex_md_start = 1, ex_md_is_div = 1 from IDLE.
  - Required: stall = 6'b001111 for exactly 33 cycles, md_run high in cycles 2–33, then md_done = 1 with stall = 0 in cycle 34.
  - After that, FSM = IDLE and stall_cycles = 33.
- Multiply behind a MEM wait, MUL_CYCLES = 2:
  - Stimulus: ex_md_start (mul) with stallreq_mem held high for 5 cycles.
  - Required: stall = 6'b011111 for 5 cycles and DONE reached after 2 cycles.
  - md_done stays high through cycles 3–6; IDLE follows once stallreq_mem drops.
- Priority:
  - Stimulus: stallreq_id = 1 and stallreq_mem = 1 together → stall = 6'b011111.
  - Then drop stallreq_mem → stall = 6'b000111.
- Flush mid-divide:
  - Stimulus: flush_req at cycle 10 of RUN.
  - Required: flush = 1 in cycle 11 with stall = 0, FSM = IDLE, and no md_done ever asserted.
- Saturation:
  - Stimulus: preload stall_cycles near the top (CNT_W = 4 build), hold stallreq_id for 20 cycles.
  - Required: stall_cycles stops at 4'hF.
